// File: rtl/net_access_controller.sv
// Network access controller: sequences SWNET/LWNET between the MEM stage and the
// local NoC router port, with a valid/ready TX latch and a small inbound RX FIFO.
module net_access_controller #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEST_WIDTH    = 8,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  NET_WRITE,
  input  logic                  NET_READ,
  input  logic [31:0]           NET_ADDR,
  input  logic [DATA_WIDTH-1:0] NET_WDATA,
  output logic                  BUSY_WAIT,
  output logic [DATA_WIDTH-1:0] NET_RDATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic [DEST_WIDTH-1:0] TX_DEST,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  input  logic                  RX_VALID,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  RX_READY,
  output logic                  RX_PENDING
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(RX_FIFO_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] RECV = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [DATA_WIDTH-1:0] mem [RX_FIFO_DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [AW:0]           count;
  logic                  push;
  logic                  pop;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^NET_ADDR[31:DEST_WIDTH];

  // Readiness comes from the registered count only, so a full FIFO refuses
  // a packet even on a cycle where it is also being popped.
  assign RX_READY   = RESET & (count != FULL_COUNT);
  assign RX_PENDING = (count != '0);
  assign push       = RX_VALID & RX_READY;
  assign pop        = (state == RECV) && (count != '0);
  assign TX_VALID   = (state == SEND);

  always_comb begin
    BUSY_WAIT = 1'b0;
    if (RESET) begin
      case (state)
        IDLE:    BUSY_WAIT = NET_WRITE | NET_READ;
        SEND:    BUSY_WAIT = 1'b1;
        RECV:    BUSY_WAIT = 1'b1;
        default: BUSY_WAIT = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (NET_WRITE)     state_nxt = SEND;
        else if (NET_READ) state_nxt = RECV;
      end
      SEND:    if (TX_READY) state_nxt = DONE;
      RECV:    if (count != '0) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= IDLE;
      TX_DEST   <= '0;
      TX_DATA   <= '0;
      NET_RDATA <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && NET_WRITE) begin
        TX_DEST <= NET_ADDR[DEST_WIDTH-1:0];
        TX_DATA <= NET_WDATA;
      end
      if (pop) NET_RDATA <= mem[rptr];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= RX_DATA;
  end

endmodule
